msg_write: RTL and testbench

- Response-frame transmitter for the UART-to-OPB bridge; the outbound counterpart of the frame parser that feeds the OPB master.
- Accepts a completed OPB read (or an optional write acknowledge) as a single-cycle request and serialises it into a 10-byte frame written byte-by-byte into the TX FIFO ahead of the UART transmitter.
- Frame layout: Header | ADDR[31:24] | ADDR[23:16] | ADDR[15:8] | ADDR[7:0] | DATA[31:24] | DATA[23:16] | DATA[15:8] | DATA[7:0] | Tail.
- Read response: header 0x5B, tail 0xA4. Write ack: header 0x5A, tail 0xA5. Tail is always ~header.

---
 rtl/msg_write.sv | 167 ++++++++++++++++
 tb/tb_msg_write.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_write.sv
// msg_write: serialises a completed OPB read (or write acknowledge) into a
// 10-byte response frame written byte-by-byte into the UART TX FIFO.
// Frame: header | addr[31:0] MSB first | data[31:0] MSB first | ~header.
module msg_write #(
  parameter bit          WR_ACK_EN   = 1'b1,
  parameter logic [15:0] STALL_LIMIT = 16'd50000
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        REQ_RD,
  input  logic        REQ_WR,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_DATA,
  output logic        TX_FIFO_WR,
  output logic [7:0]  TX_FIFO_DATA,
  input  logic        TX_FIFO_FULL,
  output logic        BUSY,
  output logic        DROP_FLAG,
  output logic        error_flag
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 16;

  localparam logic [BYTE_W-1:0] HDR_RD   = 8'h5B;
  localparam logic [BYTE_W-1:0] HDR_WR   = 8'h5A;
  localparam logic [IDX_W-1:0]  IDX_LAST = 4'd9;

  typedef struct packed {
    logic [BYTE_W-1:0] hdr;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } frame_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t            state_q,     state_d;
  frame_t            frame_q,     frame_d;
  logic [IDX_W-1:0]  byte_idx_q,  byte_idx_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              drop_q,      drop_d;

  logic              wr_req;
  logic              any_req;
  logic [CNT_W-1:0]  stall_inc;
  logic [BYTE_W-1:0] cur_byte;

  // Write requests only count when write acknowledges are enabled.
  assign wr_req    = REQ_WR && WR_ACK_EN;
  assign any_req   = REQ_RD || wr_req;
  assign stall_inc = stall_cnt_q + CNT_W'(1);

  // Frame byte selected by the current byte index.
  always_comb begin
    cur_byte = '0;
    case (byte_idx_q)
      4'd0:    cur_byte = frame_q.hdr;
      4'd1:    cur_byte = frame_q.addr[31:24];
      4'd2:    cur_byte = frame_q.addr[23:16];
      4'd3:    cur_byte = frame_q.addr[15:8];
      4'd4:    cur_byte = frame_q.addr[7:0];
      4'd5:    cur_byte = frame_q.data[31:24];
      4'd6:    cur_byte = frame_q.data[23:16];
      4'd7:    cur_byte = frame_q.data[15:8];
      4'd8:    cur_byte = frame_q.data[7:0];
      4'd9:    cur_byte = ~frame_q.hdr;
      default: cur_byte = '0;
    endcase
  end

  // State, capture, index, stall counter and drop pulse registers.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      state_q     <= ST_IDLE;
      frame_q     <= '0;
      byte_idx_q  <= '0;
      stall_cnt_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      byte_idx_q  <= byte_idx_d;
      stall_cnt_q <= stall_cnt_d;
      drop_q      <= drop_d;
    end
  end

  // Next-state logic and FIFO write path.
  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    byte_idx_d   = byte_idx_q;
    stall_cnt_d  = stall_cnt_q;
    drop_d       = 1'b0;
    TX_FIFO_WR   = 1'b0;
    TX_FIFO_DATA = '0;

    case (state_q)
      ST_IDLE: begin
        if (REQ_RD) begin
          // Read wins a collision; the losing write ack is reported as dropped.
          frame_d     = '{hdr: HDR_RD, addr: REQ_ADDR, data: REQ_DATA};
          byte_idx_d  = '0;
          stall_cnt_d = '0;
          drop_d      = wr_req;
          state_d     = ST_SEND;
        end else if (wr_req) begin
          frame_d     = '{hdr: HDR_WR, addr: REQ_ADDR, data: REQ_DATA};
          byte_idx_d  = '0;
          stall_cnt_d = '0;
          state_d     = ST_SEND;
        end
      end

      ST_SEND: begin
        drop_d = any_req;
        if (!TX_FIFO_FULL) begin
          TX_FIFO_WR   = 1'b1;
          TX_FIFO_DATA = cur_byte;
          stall_cnt_d  = '0;
          if (byte_idx_q == IDX_LAST) begin
            byte_idx_d = '0;
            state_d    = ST_DONE;
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end
        end else begin
          TX_FIFO_DATA = cur_byte;
          stall_cnt_d  = stall_inc;
          // Abandon the rest of the frame; the far end times out on it.
          if (stall_inc == STALL_LIMIT) begin
            state_d = ST_ERROR;
          end
        end
      end

      ST_DONE, ST_ERROR: begin
        drop_d      = any_req;
        byte_idx_d  = '0;
        stall_cnt_d = '0;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Data bus is only meaningful alongside the strobe.
    if (!TX_FIFO_WR) begin
      TX_FIFO_DATA = '0;
    end
  end

  // Status outputs decoded from the state register.
  assign BUSY       = (state_q != ST_IDLE);
  assign error_flag = (state_q == ST_ERROR);
  assign DROP_FLAG  = drop_q;

endmodule

// File: tb/tb_msg_write.sv
// Scoreboard bench for msg_write: expected frame bytes are queued at request
// time and compared by a monitor on every TX FIFO write.
module tb_msg_write;

  logic        OPB_CLK = 1'b0;
  logic        OPB_RST;
  logic        REQ_RD, REQ_WR;
  logic [31:0] REQ_ADDR, REQ_DATA;
  logic        TX_FIFO_FULL;
  logic        full_dir, full_rand, rand_en;

  logic        tx_wr, busy, drop, err;
  logic [7:0]  tx_data;
  logic        n_wr, n_busy, n_drop, n_err;
  logic [7:0]  n_data;

  assign TX_FIFO_FULL = full_dir | (rand_en & full_rand);

  msg_write #(.WR_ACK_EN(1'b1), .STALL_LIMIT(16'd8)) dut (
    .OPB_CLK(OPB_CLK), .OPB_RST(OPB_RST), .REQ_RD(REQ_RD), .REQ_WR(REQ_WR),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .TX_FIFO_WR(tx_wr),
    .TX_FIFO_DATA(tx_data), .TX_FIFO_FULL(TX_FIFO_FULL), .BUSY(busy),
    .DROP_FLAG(drop), .error_flag(err));

  msg_write #(.WR_ACK_EN(1'b0), .STALL_LIMIT(16'd8)) dut_n (
    .OPB_CLK(OPB_CLK), .OPB_RST(OPB_RST), .REQ_RD(REQ_RD), .REQ_WR(REQ_WR),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .TX_FIFO_WR(n_wr),
    .TX_FIFO_DATA(n_data), .TX_FIFO_FULL(TX_FIFO_FULL), .BUSY(n_busy),
    .DROP_FLAG(n_drop), .error_flag(n_err));

  always #5 OPB_CLK = ~OPB_CLK;

  int checks = 0, failures = 0;
  logic [7:0] exp_q[$];
  int wr_cnt = 0, drop_cnt = 0, err_cnt = 0;
  int n_wr_cnt = 0, n_drop_cnt = 0, n_busy_cnt = 0;
  int exp_drop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: header, address MSB first, data MSB first, inverted header.
  task automatic push_frame(input bit is_rd, input logic [31:0] a, input logic [31:0] d);
    logic [7:0] hdr;
    hdr = is_rd ? 8'h5B : 8'h5A;
    exp_q.push_back(hdr);
    for (int i = 3; i >= 0; i--) exp_q.push_back(a[8*i +: 8]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(d[8*i +: 8]);
    exp_q.push_back(~hdr);
  endtask

  // Monitor: scoreboard compare on each write plus idle-output checks.
  always @(negedge OPB_CLK) begin
    if (!OPB_RST) begin
      if (TX_FIFO_FULL) chk("wr_while_full", 32'(tx_wr), 32'd0);
      if (!busy) begin
        chk("idle_wr", 32'(tx_wr), 32'd0);
        chk("idle_data", 32'(tx_data), 32'd0);
      end
      if (tx_wr) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got %02h expected none at %0t", tx_data, $time);
        end else begin
          chk("frame_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
      if (drop)   drop_cnt++;
      if (err)    err_cnt++;
      if (n_wr)   n_wr_cnt++;
      if (n_drop) n_drop_cnt++;
      if (n_busy) n_busy_cnt++;
    end
  end

  // Random backpressure with stall runs kept well below the abort limit.
  int run = 0;
  always @(posedge OPB_CLK) begin
    #1;
    if (run >= 3) begin
      full_rand = 1'b0;
      run = 0;
    end else begin
      full_rand = ($urandom_range(0, 3) == 0);
      run = full_rand ? run + 1 : 0;
    end
  end

  task automatic tick();
    @(posedge OPB_CLK);
    #1;
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    REQ_RD = rd; REQ_WR = wr; REQ_ADDR = a; REQ_DATA = d;
    if (rd) push_frame(1'b1, a, d);
    else if (wr) push_frame(1'b0, a, d);
    tick();
    REQ_RD = 1'b0; REQ_WR = 1'b0;
    REQ_ADDR = $urandom; REQ_DATA = $urandom;
  endtask

  // Waits until every expected byte is out and the DONE cycle has passed;
  // optionally fires requests mid-frame that must be dropped.
  task automatic wait_frame_done(input bit inject);
    int n = 0;
    forever begin
      if (exp_q.size() == 0) break;
      if (n > 300) begin
        checks++; failures++;
        $display("FAIL frame_timeout: got %0d bytes pending expected 0", exp_q.size());
        exp_q.delete();
        break;
      end
      if (inject && $urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) REQ_RD = 1'b1; else REQ_WR = 1'b1;
        REQ_ADDR = $urandom; REQ_DATA = $urandom;
        exp_drop++;
      end
      tick();
      REQ_RD = 1'b0; REQ_WR = 1'b0;
      n++;
    end
    tick();
  endtask

  task automatic wait_bytes(input int target);
    int n = 0;
    while (wr_cnt < target && n < 60) begin
      tick();
      n++;
    end
    chk("wait_bytes", 32'(wr_cnt), 32'(target));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int b_wr, b_drop, b_err, b_nwr, b_ndrop, b_nbusy;

  initial begin
    OPB_RST = 1'b1; REQ_RD = 1'b0; REQ_WR = 1'b0;
    REQ_ADDR = '0; REQ_DATA = '0; full_dir = 1'b0; rand_en = 1'b0;

    // Reset state.
    @(negedge OPB_CLK);
    @(negedge OPB_CLK);
    chk("rst_wr", 32'(tx_wr), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge OPB_CLK); #1 OPB_RST = 1'b0;
    tick(); tick();

    // Read response with free FIFO: 10 back-to-back writes then DONE.
    b_drop = drop_cnt; b_err = err_cnt;
    chk("req_cycle_busy", 32'(busy), 32'd0);
    issue(1'b1, 1'b0, 32'h12345678, 32'hDEADBEEF);
    for (int i = 0; i < 10; i++) begin
      @(negedge OPB_CLK);
      chk("consec_wr", 32'(tx_wr), 32'd1);
      chk("send_busy", 32'(busy), 32'd1);
    end
    @(negedge OPB_CLK);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_wr", 32'(tx_wr), 32'd0);
    @(negedge OPB_CLK);
    chk("post_busy", 32'(busy), 32'd0);
    chk("rd_no_drop", 32'(drop_cnt - b_drop), 32'd0);
    chk("rd_no_err", 32'(err_cnt - b_err), 32'd0);
    tick();

    // Write ack, and the write-ack-disabled instance stays silent.
    b_nwr = n_wr_cnt; b_ndrop = n_drop_cnt; b_nbusy = n_busy_cnt; b_drop = drop_cnt;
    issue(1'b0, 1'b1, 32'h00000010, 32'h000000FF);
    wait_frame_done(1'b0);
    repeat (3) tick();
    chk("wrack_n_wr", 32'(n_wr_cnt - b_nwr), 32'd0);
    chk("wrack_n_busy", 32'(n_busy_cnt - b_nbusy), 32'd0);
    chk("wrack_n_drop", 32'(n_drop_cnt - b_ndrop), 32'd0);
    chk("wrack_drop", 32'(drop_cnt - b_drop), 32'd0);

    // Backpressure for 3 cycles after byte 4.
    b_wr = wr_cnt; b_err = err_cnt;
    issue(1'b1, 1'b0, 32'hA1B2C3D4, 32'h0F1E2D3C);
    wait_bytes(b_wr + 5);
    full_dir = 1'b1;
    repeat (3) tick();
    full_dir = 1'b0;
    wait_frame_done(1'b0);
    chk("bp_bytes", 32'(wr_cnt - b_wr), 32'd10);
    chk("bp_no_err", 32'(err_cnt - b_err), 32'd0);

    // Stall abort after 2 bytes, then a clean frame.
    b_wr = wr_cnt; b_err = err_cnt;
    issue(1'b1, 1'b0, 32'hCAFEF00D, 32'h13579BDF);
    wait_bytes(b_wr + 2);
    full_dir = 1'b1;
    for (int n = 0; n < 40 && err_cnt == b_err; n++) tick();
    full_dir = 1'b0;
    chk("stall_bytes", 32'(wr_cnt - b_wr), 32'd2);
    exp_q.delete();
    repeat (3) tick();
    chk("stall_err_once", 32'(err_cnt - b_err), 32'd1);
    chk("stall_idle", 32'(busy), 32'd0);
    b_wr = wr_cnt;
    issue(1'b1, 1'b0, 32'h55AA00FF, 32'h87654321);
    wait_frame_done(1'b0);
    chk("after_stall_bytes", 32'(wr_cnt - b_wr), 32'd10);

    // Read/write collision: read frame, one drop (none when acks disabled).
    b_drop = drop_cnt; b_ndrop = n_drop_cnt;
    issue(1'b1, 1'b1, 32'h0BADCAFE, 32'h600DF00D);
    wait_frame_done(1'b0);
    repeat (2) tick();
    chk("collide_drop", 32'(drop_cnt - b_drop), 32'd1);
    chk("collide_n_drop", 32'(n_drop_cnt - b_ndrop), 32'd0);

    // Read during SEND is dropped without touching the frame.
    b_drop = drop_cnt; b_wr = wr_cnt;
    issue(1'b1, 1'b0, 32'h11223344, 32'h55667788);
    wait_bytes(b_wr + 3);
    REQ_RD = 1'b1; REQ_ADDR = 32'hFFFFFFFF; REQ_DATA = 32'h00000000;
    tick();
    REQ_RD = 1'b0;
    wait_frame_done(1'b0);
    repeat (2) tick();
    chk("busy_drop", 32'(drop_cnt - b_drop), 32'd1);
    chk("busy_drop_bytes", 32'(wr_cnt - b_wr), 32'd10);

    // Reset mid-frame after byte 5.
    b_wr = wr_cnt;
    issue(1'b1, 1'b0, 32'h99887766, 32'h44332211);
    wait_bytes(b_wr + 6);
    OPB_RST = 1'b1;
    #1;
    chk("mrst_wr", 32'(tx_wr), 32'd0);
    chk("mrst_data", 32'(tx_data), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_drop", 32'(drop), 32'd0);
    chk("mrst_err", 32'(err), 32'd0);
    exp_q.delete();
    @(posedge OPB_CLK); @(posedge OPB_CLK);
    #1 OPB_RST = 1'b0;
    tick();
    b_wr = wr_cnt;
    issue(1'b0, 1'b1, 32'h00C0FFEE, 32'hFEEDFACE);
    wait_frame_done(1'b0);
    chk("mrst_new_bytes", 32'(wr_cnt - b_wr), 32'd10);

    // Random frames, random backpressure, random mid-frame drops; each new
    // request lands in the first IDLE cycle after DONE.
    rand_en = 1'b1;
    exp_drop = 0; b_drop = drop_cnt; b_err = err_cnt; b_wr = wr_cnt;
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 1) == 1) issue(1'b1, 1'b0, $urandom, $urandom);
      else issue(1'b0, 1'b1, $urandom, $urandom);
      wait_frame_done(1'b1);
    end
    rand_en = 1'b0;
    repeat (3) tick();
    chk("rand_bytes", 32'(wr_cnt - b_wr), 32'd300);
    chk("rand_drops", 32'(drop_cnt - b_drop), 32'(exp_drop));
    chk("rand_no_err", 32'(err_cnt - b_err), 32'd0);
    chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
